// File: rtl/pid_sched_pkg.sv
// Shared types for the PID channel scheduler: sweep FSM states and width helpers.
// Pure declarations, no logic.
package pid_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        WRITE = 2'd3
    } sched_state_t;

    localparam int DEF_NCH = 4;
    localparam int DEF_DW  = 8;
    localparam int DEF_AW  = 16;
    localparam int DEF_DIV = 1000;

    // Channel index width, never narrower than one bit.
    function automatic int ch_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pid_tick_gen.sv
// Sample-rate tick: counts 0..DIV-1 while enabled, held at 0 when disabled.
// Latency: tick is combinational from the count; no backpressure.
module pid_tick_gen #(
    parameter int DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);
    localparam int TW = (DIV <= 2) ? 1 : $clog2(DIV);
    localparam logic [TW-1:0] LAST = TW'(DIV - 1);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!enable || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + TW'(1);
        end
    end

    assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/pid_channel_scheduler.sv
// Sweeps one shared PID engine over NCH channels per tick; 1 cycle tick->eng_valid, 3 cycles/channel.
// Backpressure: request held stable until eng_ready; waits indefinitely for res_valid.
module pid_channel_scheduler
    import pid_sched_pkg::*;
#(
    parameter int NCH = DEF_NCH,
    parameter int DW  = DEF_DW,
    parameter int AW  = DEF_AW,
    parameter int DIV = DEF_DIV
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [NCH-1:0]           clear_ch,
    input  logic [NCH*DW-1:0]        setpoint_in,
    input  logic [NCH*DW-1:0]        feedback_in,
    output logic                     eng_valid,
    input  logic                     eng_ready,
    output logic [ch_idx_w(NCH)-1:0] eng_ch,
    output logic signed [DW:0]       eng_error,
    output logic signed [DW:0]       eng_prev_err,
    output logic signed [AW-1:0]     eng_integ,
    input  logic                     res_valid,
    input  logic signed [AW-1:0]     res_integ,
    input  logic [DW-1:0]            res_ctrl,
    output logic [NCH*DW-1:0]        control_out,
    output logic [NCH-1:0]           ctrl_update,
    output logic                     busy,
    output logic                     overrun
);
    localparam int CW = ch_idx_w(NCH);
    localparam logic [CW-1:0] LAST_CH = CW'(NCH - 1);

    sched_state_t         state, state_nxt;
    logic [CW-1:0]        ch, load_ch;
    logic                 load_req;
    logic                 tick;
    logic [DW-1:0]        sp_sel, fb_sel;
    logic signed [AW-1:0] integ_q [NCH];
    logic signed [DW:0]   prev_q  [NCH];
    logic signed [AW-1:0] res_integ_q;
    logic [DW-1:0]        res_ctrl_q;

    pid_tick_gen #(
        .DIV    (DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .tick   (tick)
    );

    always_comb begin
        state_nxt = state;
        load_req  = 1'b0;
        load_ch   = ch;
        case (state)
            IDLE: begin
                if (tick && enable) begin
                    state_nxt = ISSUE;
                    load_req  = 1'b1;
                    load_ch   = '0;
                end
            end
            ISSUE: begin
                if (eng_ready) state_nxt = WAIT;
            end
            WAIT: begin
                if (res_valid) state_nxt = WRITE;
            end
            WRITE: begin
                // Enable is only honoured here, so a started channel always completes.
                if (ch == LAST_CH || !enable) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = ISSUE;
                    load_req  = 1'b1;
                    load_ch   = ch + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign sp_sel    = setpoint_in[load_ch*DW +: DW];
    assign fb_sel    = feedback_in[load_ch*DW +: DW];
    assign eng_valid = (state == ISSUE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ch           <= '0;
            eng_ch       <= '0;
            eng_error    <= '0;
            eng_prev_err <= '0;
            eng_integ    <= '0;
            res_integ_q  <= '0;
            res_ctrl_q   <= '0;
            overrun      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load_req) begin
                ch           <= load_ch;
                eng_ch       <= load_ch;
                eng_error    <= {1'b0, sp_sel} - {1'b0, fb_sel};
                eng_prev_err <= prev_q[load_ch];
                eng_integ    <= integ_q[load_ch];
            end
            if (state == WAIT && res_valid) begin
                res_integ_q <= res_integ;
                res_ctrl_q  <= res_ctrl;
            end
            if (tick && state != IDLE) overrun <= 1'b1;
        end
    end

    // Per-channel state file; a clear beats a same-cycle write-back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                integ_q[i] <= '0;
                prev_q[i]  <= '0;
            end
            control_out <= '0;
            ctrl_update <= '0;
        end else begin
            ctrl_update <= '0;
            if (state == WRITE) begin
                control_out[ch*DW +: DW] <= res_ctrl_q;
                ctrl_update[ch]          <= 1'b1;
            end
            for (int i = 0; i < NCH; i++) begin
                if (clear_ch[i]) begin
                    integ_q[i] <= '0;
                    prev_q[i]  <= '0;
                end else if (state == WRITE && ch == CW'(i)) begin
                    integ_q[i] <= res_integ_q;
                    prev_q[i]  <= eng_error;
                end
            end
        end
    end

endmodule

// File: tb/tb_pid_channel_scheduler.sv
// Randomised bench for pid_channel_scheduler with a channel-level reference model.
// The engine is emulated inline; all expectations come from the model state below.
module tb_pid_channel_scheduler;
    localparam int NCH = 4;
    localparam int DW  = 8;
    localparam int AW  = 16;
    localparam int DIV = 16;
    localparam int CW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic [NCH-1:0]    clear_ch;
    logic [NCH*DW-1:0] setpoint_in;
    logic [NCH*DW-1:0] feedback_in;
    logic              eng_valid;
    logic              eng_ready;
    logic [CW-1:0]     eng_ch;
    logic [DW:0]       eng_error;
    logic [DW:0]       eng_prev_err;
    logic [AW-1:0]     eng_integ;
    logic              res_valid;
    logic [AW-1:0]     res_integ;
    logic [DW-1:0]     res_ctrl;
    logic [NCH*DW-1:0] control_out;
    logic [NCH-1:0]    ctrl_update;
    logic              busy;
    logic              overrun;

    always #5 clk = ~clk;

    pid_channel_scheduler #(
        .NCH(NCH), .DW(DW), .AW(AW), .DIV(DIV)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .clear_ch     (clear_ch),
        .setpoint_in  (setpoint_in),
        .feedback_in  (feedback_in),
        .eng_valid    (eng_valid),
        .eng_ready    (eng_ready),
        .eng_ch       (eng_ch),
        .eng_error    (eng_error),
        .eng_prev_err (eng_prev_err),
        .eng_integ    (eng_integ),
        .res_valid    (res_valid),
        .res_integ    (res_integ),
        .res_ctrl     (res_ctrl),
        .control_out  (control_out),
        .ctrl_update  (ctrl_update),
        .busy         (busy),
        .overrun      (overrun)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: what each channel should have stored.
    logic [AW-1:0] m_integ [NCH];
    logic [DW:0]   m_prev  [NCH];
    logic [DW-1:0] m_ctrl  [NCH];
    bit            ov_exp;
    int            last_start;
    int            exp_gap;

    // Per-sweep engine behaviour.
    int  rdy_dly [NCH];
    int  res_dly [NCH];
    bit  clr_wr  [NCH];
    int  drop_at;
    int  rst_at;
    bit  echo;
    bit  rnd_clr;

    logic [NCH-1:0] msk;
    int             viol;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NCH*DW-1:0] model_ctrl_bus();
        logic [NCH*DW-1:0] v;
        for (int i = 0; i < NCH; i++) v[i*DW +: DW] = m_ctrl[i];
        return v;
    endfunction

    function automatic logic [DW:0] exp_err(input int c);
        int e;
        e = int'(setpoint_in[c*DW +: DW]) - int'(feedback_in[c*DW +: DW]);
        return e[DW:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_integ[i] = '0;
            m_prev[i]  = '0;
            m_ctrl[i]  = '0;
        end
        ov_exp = 1'b0;
    endtask

    task automatic cfg(input int rd, input int rs);
        for (int i = 0; i < NCH; i++) begin
            rdy_dly[i] = rd;
            res_dly[i] = rs;
            clr_wr[i]  = 1'b0;
        end
        drop_at = -1;
        rst_at  = -1;
    endtask

    task automatic wait_valid(output int w);
        w = 0;
        while (!eng_valid && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!eng_valid) check("valid_timeout", 0, 1);
    endtask

    task automatic do_reset_mid();
        int v;
        rst = 1'b1;
        #1;
        check("rst_eng_valid", eng_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_control_out", control_out, 0);
        check("rst_overrun", overrun, 0);
        enable = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        v = 0;
        for (int k = 0; k < 4; k++) begin
            res_valid = 1'b1;
            res_integ = AW'($urandom);
            res_ctrl  = 8'hff;
            @(negedge clk);
            if (busy !== 1'b0 || eng_valid !== 1'b0 || ctrl_update !== '0 || control_out !== '0) v++;
        end
        res_valid = 1'b0;
        check("rst_stray_res", v, 0);
    endtask

    task automatic sweep(input int exp_wait, input bit cont);
        int            w, b_exp, start, v;
        logic [DW:0]   e;
        logic [AW-1:0] ri;
        logic [DW-1:0] rc;
        logic [CW-1:0] exp_ch;
        logic [NCH-1:0] cm;
        b_exp = 0;
        wait_valid(w);
        if (exp_wait >= 0) check("start_latency", w, exp_wait);
        start = cyc;
        if (cont) check("tick_period", start - last_start, exp_gap);
        for (int c = 0; c < NCH; c++) begin
            if (c > 0) begin
                wait_valid(w);
                check("next_issue_gap", w, 0);
            end
            e      = exp_err(c);
            exp_ch = CW'(c);
            check("eng_ch", eng_ch, exp_ch);
            check("eng_error", eng_error, e);
            check("eng_prev_err", eng_prev_err, m_prev[c]);
            check("eng_integ", eng_integ, m_integ[c]);
            check("busy_on", busy, 1);
            if (c == drop_at) enable = 1'b0;

            // Hold off acceptance; inputs wander and stray results arrive.
            v = 0;
            for (int k = 0; k < rdy_dly[c]; k++) begin
                eng_ready = 1'b0;
                res_valid = 1'($urandom_range(0, 1));
                res_integ = AW'($urandom);
                res_ctrl  = DW'($urandom);
                setpoint_in[c*DW +: DW] = DW'($urandom);
                feedback_in[c*DW +: DW] = DW'($urandom);
                @(negedge clk);
                if (eng_valid !== 1'b1 || eng_ch !== exp_ch || eng_error !== e ||
                    eng_prev_err !== m_prev[c] || eng_integ !== m_integ[c] || ctrl_update !== '0) v++;
            end
            res_valid = 1'b0;
            if (rdy_dly[c] > 0) check("hold_stable", v, 0);

            eng_ready = 1'b1;
            @(negedge clk);
            eng_ready = 1'b0;
            check("accept_drops_valid", eng_valid, 0);
            if (c == rst_at) begin
                do_reset_mid();
                return;
            end

            v = 0;
            for (int k = 0; k < res_dly[c]; k++) begin
                cm = (rnd_clr && $urandom_range(0, 3) == 0) ? NCH'($urandom) : '0;
                clear_ch = cm;
                @(negedge clk);
                for (int i = 0; i < NCH; i++) begin
                    if (cm[i]) begin
                        m_integ[i] = '0;
                        m_prev[i]  = '0;
                    end
                end
                if (eng_valid !== 1'b0 || ctrl_update !== '0 || busy !== 1'b1) v++;
            end
            clear_ch = '0;
            if (res_dly[c] > 0) check("wait_quiet", v, 0);

            ri = clr_wr[c] ? 16'h0123 : AW'($urandom);
            rc = echo ? e[DW-1:0] : DW'($urandom);
            res_valid = 1'b1;
            res_integ = ri;
            res_ctrl  = rc;
            @(negedge clk);
            res_valid   = 1'b0;
            res_integ   = ~ri;
            res_ctrl    = ~rc;
            clear_ch[c] = clr_wr[c];
            @(negedge clk);
            clear_ch = '0;
            m_ctrl[c] = rc;
            if (clr_wr[c]) begin
                m_integ[c] = '0;
                m_prev[c]  = '0;
            end else begin
                m_integ[c] = ri;
                m_prev[c]  = e;
            end
            check("ctrl_update", ctrl_update, NCH'(1) << c);
            check("control_out", control_out, model_ctrl_bus());
            b_exp += 3 + rdy_dly[c] + res_dly[c];
            if (c == drop_at) break;
        end
        check("sweep_len", cyc - start, b_exp);
        check("busy_end", busy, 0);
        if (drop_at < 0 && b_exp >= DIV) ov_exp = 1'b1;
        check("overrun", overrun, ov_exp);
        exp_gap    = DIV * (b_exp / DIV + 1);
        last_start = start;
        res_valid  = 1'b1;
        res_integ  = AW'($urandom);
        res_ctrl   = DW'($urandom);
        @(negedge clk);
        res_valid = 1'b0;
        check("idle_res_ignored", ctrl_update, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        enable      = 1'b0;
        clear_ch    = '0;
        setpoint_in = '0;
        feedback_in = '0;
        eng_ready   = 1'b0;
        res_valid   = 1'b0;
        res_integ   = '0;
        res_ctrl    = '0;
        echo        = 1'b0;
        rnd_clr     = 1'b0;
        last_start  = 0;
        exp_gap     = 0;
        model_reset();
        cfg(0, 0);
        repeat (2) @(negedge clk);
        check("reset_eng_valid", eng_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_overrun", overrun, 0);
        check("reset_control_out", control_out, 0);
        check("reset_ctrl_update", ctrl_update, 0);
        check("reset_eng_integ", eng_integ, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed sweep: errors 5,100,-10,0 echoed back as control values.
        setpoint_in = {8'd0, 8'd50, 8'd200, 8'd10};
        feedback_in = {8'd0, 8'd60, 8'd100, 8'd5};
        echo   = 1'b1;
        enable = 1'b1;
        sweep(DIV, 1'b0);
        check("echo_control_out", control_out, 32'h00f66405);
        echo = 1'b0;

        // Clear on ch2 write-back, then a light-backpressure sweep that reissues ch2.
        cfg(0, 0);
        clr_wr[2]   = 1'b1;
        setpoint_in = $urandom;
        feedback_in = $urandom;
        sweep(-1, 1'b1);
        cfg(0, 0);
        rdy_dly[1] = 1;
        res_dly[3] = 2;
        sweep(-1, 1'b1);

        // Slow engine: sweep outlasts the tick period.
        cfg(0, 0);
        res_dly[1] = 20;
        sweep(-1, 1'b1);

        // Engine refuses ch0 for five cycles.
        cfg(0, 0);
        rdy_dly[0] = 5;
        sweep(-1, 1'b1);

        // Enable dropped while ch1 is being issued.
        cfg(0, 0);
        drop_at = 1;
        sweep(-1, 1'b1);
        msk = NCH'($urandom) | 4'b0001;
        clear_ch = msk;
        @(negedge clk);
        clear_ch = '0;
        for (int i = 0; i < NCH; i++) begin
            if (msk[i]) begin
                m_integ[i] = '0;
                m_prev[i]  = '0;
            end
        end
        viol = 0;
        repeat (40) begin
            @(negedge clk);
            if (eng_valid !== 1'b0 || busy !== 1'b0) viol++;
        end
        check("disabled_idle", viol, 0);
        cfg(0, 0);
        enable = 1'b1;
        sweep(DIV, 1'b0);

        // Random traffic.
        rnd_clr = 1'b1;
        for (int s = 0; s < 8; s++) begin
            cfg(0, 0);
            for (int i = 0; i < NCH; i++) begin
                rdy_dly[i] = $urandom_range(0, 3);
                res_dly[i] = $urandom_range(0, 3);
                clr_wr[i]  = ($urandom_range(0, 3) == 0);
            end
            setpoint_in = $urandom;
            feedback_in = $urandom;
            sweep(-1, 1'b1);
        end
        rnd_clr = 1'b0;

        // Reset while waiting for ch2's result, then a fresh sweep sees cleared state.
        cfg(0, 0);
        rst_at = 2;
        sweep(-1, 1'b1);
        cfg(0, 0);
        enable = 1'b1;
        sweep(DIV, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
